cpu_loader: RTL and testbench
=============================

CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 Parameter SIZE, 13, RAM address width; matches the CPU address and pCounter width.
REQ-002 Parameter HALT_CYCLES, 16, consecutive cycles of unchanged cpu_pCounter that count as a halt; legal range 8..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load_start  input  1  one-cycle request to (re)load a program.
REQ-006 load_len  input  SIZE  number of 16-bit words to load; sampled on the cycle load_start is accepted.
REQ-007 in_valid  input  1  loader word valid.
REQ-008 in_data  input  16  loader word.
REQ-009 in_ready  output  1  loader word accepted when in_valid and in_ready are both 1.
REQ-010 cpu_wrEn  input  1  CPU write enable.
REQ-011 cpu_addr  input  SIZE  CPU address.
REQ-012 cpu_data  input  16  CPU write data.
REQ-013 cpu_pCounter  input  SIZE  CPU program counter, used for halt detection.
REQ-014 cpu_rst  output  1  reset driven to the CPU.
REQ-015 ram_wrEn  output  1  RAM write enable.
REQ-016 ram_addr  output  SIZE  RAM address.
REQ-017 ram_data  output  16  RAM write data.
REQ-018 busy  output  1  high in LOAD and RELEASE.
REQ-019 halted  output  1  high in HALT.
REQ-020 run_cycles  output  16  number of RUN cycles since the last RUN entry; saturates at 0xFFFF.

Function
REQ-021 FSM states: IDLE, LOAD, RELEASE, RUN, HALT.
REQ-022 IDLE: load_start=1 -> LOAD; word pointer cleared; load_len latched into len_reg.
REQ-023 LOAD: in_ready=1; ram_wrEn=in_valid; ram_addr=ptr; ram_data=in_data; all driven combinationally.
REQ-024 LOAD: each handshake increments ptr (mod 2^SIZE); when the accepting handshake makes ptr equal len_reg -> RELEASE next cycle.
REQ-025 LOAD with len_reg=0 -> RELEASE next cycle, no RAM write.
REQ-026 load_start in LOAD or RELEASE is ignored.
REQ-027 RELEASE lasts exactly one cycle -> RUN; it guarantees the CPU sees at least one clock edge with cpu_rst=1 after the final write.
REQ-028 cpu_rst=1 in every state except RUN; it is decoded from the registered state.
REQ-029 RUN: ram_wrEn/ram_addr/ram_data = cpu_wrEn/cpu_addr/cpu_data combinationally; in_ready=0.
REQ-030 IDLE, RELEASE, HALT: ram_wrEn=0, ram_addr=0, ram_data=0, in_ready=0.
REQ-031 pc_prev register samples cpu_pCounter every cycle.
REQ-032 stall_cnt (8 bit) is cleared on entry to RUN.
REQ-033 In RUN: stall_cnt increments when cpu_pCounter==pc_prev, else clears; reaching HALT_CYCLES -> HALT next cycle.
REQ-034 run_cycles is cleared on entry to RUN, increments each RUN cycle, and holds in all other states.
REQ-035 load_start in RUN or HALT -> LOAD next cycle (abort); cpu_rst rises the same edge; len_reg relatched, ptr cleared.
REQ-036 HALT holds until load_start; halted=1.

Reset
REQ-037 rst=1 at a clock edge -> state IDLE, ptr=0, len_reg=0, stall_cnt=0, run_cycles=0, pc_prev=0, from any state including mid-LOAD.
REQ-038 Output values during and after reset: cpu_rst=1, in_ready=0, ram_wrEn=0, ram_addr=0, ram_data=0, busy=0, halted=0.
REQ-039 rst takes priority over load_start in the same cycle.

Verification
REQ-040 Reset, then load_start with load_len=3 and words 0x1111, 0x2222, 0x3333 with continuous valid -> RAM writes at addresses 0, 1, 2; RELEASE for 1 cycle; RUN with cpu_rst=0 on the 5th cycle after load_start.
REQ-041 load_len=4 with in_valid toggled 1,0,1,0,... -> exactly 4 writes; ptr advances only on handshakes; in_ready stays 1 throughout LOAD.
REQ-042 load_len=0 -> IDLE, LOAD, RELEASE, RUN on consecutive cycles; no ram_wrEn pulse.
REQ-043 RUN with cpu_pCounter constant at 0x0005 -> halted=1 after HALT_CYCLES+1 cycles; with pCounter changing every 6 cycles -> never halts; run_cycles matches the cycle count.
REQ-044 load_start during RUN -> cpu_rst=1 the next cycle, CPU writes blocked, new load proceeds from address 0.
REQ-045 rst asserted after 2 of 5 words -> IDLE, no further writes; load_start during LOAD is ignored.

Source files
------------

// File: rtl/cpu_loader_if.sv
// Loader, CPU and RAM port bundle for cpu_loader.
// The slave side is the loader; the master side drives requests and CPU traffic.
interface cpu_loader_if #(
  parameter int SIZE = 13
);
  logic            load_start;
  logic [SIZE-1:0] load_len;
  logic            in_valid;
  logic [15:0]     in_data;
  logic            in_ready;
  logic            cpu_wrEn;
  logic [SIZE-1:0] cpu_addr;
  logic [15:0]     cpu_data;
  logic [SIZE-1:0] cpu_pCounter;
  logic            cpu_rst;
  logic            ram_wrEn;
  logic [SIZE-1:0] ram_addr;
  logic [15:0]     ram_data;
  logic            busy;
  logic            halted;
  logic [15:0]     run_cycles;

  modport slave (
    input  load_start, load_len,
    input  in_valid, in_data,
    output in_ready,
    input  cpu_wrEn, cpu_addr,
    input  cpu_data, cpu_pCounter,
    output cpu_rst,
    output ram_wrEn, ram_addr, ram_data,
    output busy, halted, run_cycles
  );

  modport master (
    output load_start, load_len,
    output in_valid, in_data,
    input  in_ready,
    output cpu_wrEn, cpu_addr,
    output cpu_data, cpu_pCounter,
    input  cpu_rst,
    input  ram_wrEn, ram_addr, ram_data,
    input  busy, halted, run_cycles
  );
endinterface

// File: rtl/cpu_loader.sv
// Program loader: streams words into RAM while holding the CPU in reset,
// then releases it and watches the program counter for a halt.
module cpu_loader #(
  parameter int SIZE        = 13,
  parameter int HALT_CYCLES = 16
) (
  input logic         clk,
  input logic         rst,
  cpu_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RELEASE, RUN, HALT
  } state_t;

  state_t          state, state_nx;
  logic [SIZE-1:0] ptr, ptr_nx;
  logic [SIZE-1:0] len_reg, len_nx;
  logic [SIZE-1:0] ptr_inc;
  logic [SIZE-1:0] pc_prev;
  logic [7:0]      stall_cnt, stall_nx;
  logic [15:0]     run_cnt, run_nx;

  assign ptr_inc = ptr + SIZE'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      len_reg   <= '0;
      stall_cnt <= '0;
      run_cnt   <= '0;
      pc_prev   <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      len_reg   <= len_nx;
      stall_cnt <= stall_nx;
      run_cnt   <= run_nx;
      pc_prev   <= bus.cpu_pCounter;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    len_nx   = len_reg;
    stall_nx = stall_cnt;
    run_nx   = run_cnt;
    unique case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_nx = LOAD;
          ptr_nx   = '0;
          len_nx   = bus.load_len;
        end
      end
      LOAD: begin
        if (len_reg == '0) begin
          state_nx = RELEASE;
        end else if (bus.in_valid) begin
          ptr_nx = ptr_inc;
          if (ptr_inc == len_reg)
            state_nx = RELEASE;
        end
      end
      RELEASE: begin
        state_nx = RUN;
        stall_nx = '0;
        run_nx   = '0;
      end
      RUN: begin
        if (run_cnt != 16'hFFFF)
          run_nx = run_cnt + 16'd1;
        if (bus.cpu_pCounter != pc_prev)
          stall_nx = '0;
        else if (stall_cnt != 8'hFF)
          stall_nx = stall_cnt + 8'd1;
        if (stall_cnt >= 8'(HALT_CYCLES))
          state_nx = HALT;
        // a new request aborts the running program
        if (bus.load_start) begin
          state_nx = LOAD;
          ptr_nx   = '0;
          len_nx   = bus.load_len;
        end
      end
      HALT: begin
        if (bus.load_start) begin
          state_nx = LOAD;
          ptr_nx   = '0;
          len_nx   = bus.load_len;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = 1'b0;
    bus.cpu_rst    = 1'b1;
    bus.ram_wrEn   = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_data   = '0;
    bus.busy       = 1'b0;
    bus.halted     = 1'b0;
    bus.run_cycles = run_cnt;
    // reset forces the idle view even before the state register clears
    if (!rst) begin
      unique case (state)
        LOAD: begin
          bus.in_ready = 1'b1;
          bus.ram_wrEn = bus.in_valid
                       && (len_reg != '0);
          bus.ram_addr = ptr;
          bus.ram_data = bus.in_data;
          bus.busy     = 1'b1;
        end
        RELEASE: bus.busy = 1'b1;
        RUN: begin
          bus.cpu_rst  = 1'b0;
          bus.ram_wrEn = bus.cpu_wrEn;
          bus.ram_addr = bus.cpu_addr;
          bus.ram_data = bus.cpu_data;
        end
        HALT: bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// Directed bench for cpu_loader: load, release, run, halt,
// abort and reset scenarios with hand-computed expectations.
module tb_cpu_loader;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   wr_cnt = 0;
  int   w;

  cpu_loader_if #(.SIZE(13)) bus ();

  cpu_loader #(
    .SIZE(13),
    .HALT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.ram_wrEn === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.load_start   = 1'b1;
    bus.load_len     = 13'd7;
    bus.in_valid     = 1'b0;
    bus.in_data      = 16'h0;
    bus.cpu_wrEn     = 1'b0;
    bus.cpu_addr     = 13'h0;
    bus.cpu_data     = 16'h0;
    bus.cpu_pCounter = 13'h5;

    // reset with a competing load request
    step();
    #1;
    chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wren", 32'(bus.ram_wrEn), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_data", 32'(bus.ram_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    step();
    rst = 1'b0;
    bus.load_start = 1'b0;
    #1;
    chk("rst_prio_busy", 32'(bus.busy), 32'd0);
    chk("idle_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("idle_runc", 32'(bus.run_cycles), 32'd0);

    // three-word load, continuous valid
    bus.load_start = 1'b1;
    bus.load_len   = 13'd3;
    #1;
    chk("idle_ready", 32'(bus.in_ready), 32'd0);
    w = wr_cnt;
    step();
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_data    = 16'h1111;
    #1;
    chk("l3_ready", 32'(bus.in_ready), 32'd1);
    chk("l3_busy", 32'(bus.busy), 32'd1);
    chk("l3_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("l3_wren0", 32'(bus.ram_wrEn), 32'd1);
    chk("l3_addr0", 32'(bus.ram_addr), 32'd0);
    chk("l3_data0", 32'(bus.ram_data), 32'h1111);
    step();
    bus.in_data = 16'h2222;
    #1;
    chk("l3_addr1", 32'(bus.ram_addr), 32'd1);
    chk("l3_data1", 32'(bus.ram_data), 32'h2222);
    step();
    bus.in_data = 16'h3333;
    #1;
    chk("l3_addr2", 32'(bus.ram_addr), 32'd2);
    chk("l3_data2", 32'(bus.ram_data), 32'h3333);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("rel_busy", 32'(bus.busy), 32'd1);
    chk("rel_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("rel_ready", 32'(bus.in_ready), 32'd0);
    chk("rel_wren", 32'(bus.ram_wrEn), 32'd0);
    chk("l3_writes", 32'(wr_cnt - w), 32'd3);
    step();
    bus.cpu_wrEn = 1'b1;
    bus.cpu_addr = 13'h10;
    bus.cpu_data = 16'hABCD;
    #1;
    chk("run_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    chk("run_busy", 32'(bus.busy), 32'd0);
    chk("run_wren", 32'(bus.ram_wrEn), 32'd1);
    chk("run_addr", 32'(bus.ram_addr), 32'h10);
    chk("run_data", 32'(bus.ram_data), 32'hABCD);
    chk("run_runc0", 32'(bus.run_cycles), 32'd0);
    bus.cpu_wrEn = 1'b0;

    // constant pCounter: halt after HALT_CYCLES+1 cycles
    repeat (16) step();
    chk("pre_halt", 32'(bus.halted), 32'd0);
    chk("pre_runc", 32'(bus.run_cycles), 32'd16);
    step();
    chk("halt", 32'(bus.halted), 32'd1);
    chk("halt_runc", 32'(bus.run_cycles), 32'd17);
    chk("halt_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    bus.cpu_wrEn = 1'b1;
    #1;
    chk("halt_wren", 32'(bus.ram_wrEn), 32'd0);
    step();
    chk("halt_hold_runc", 32'(bus.run_cycles), 32'd17);
    bus.cpu_wrEn = 1'b0;

    // restart from HALT, valid toggling
    bus.load_start = 1'b1;
    bus.load_len   = 13'd4;
    w = wr_cnt;
    step();
    bus.load_start = 1'b0;
    #1;
    chk("l4_busy", 32'(bus.busy), 32'd1);
    chk("l4_halted", 32'(bus.halted), 32'd0);
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 16'hA000 + 16'(i);
      #1;
      chk("l4_ready", 32'(bus.in_ready), 32'd1);
      chk("l4_wren", 32'(bus.ram_wrEn),
          32'(i % 2 == 0));
      chk("l4_addr", 32'(bus.ram_addr),
          32'((i + 1) / 2));
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("l4_rel_busy", 32'(bus.busy), 32'd1);
    chk("l4_rel_ready", 32'(bus.in_ready), 32'd0);
    chk("l4_writes", 32'(wr_cnt - w), 32'd4);
    step();
    chk("l4_run", 32'(bus.cpu_rst), 32'd0);

    // pCounter changes every 6 cycles: no halt
    for (int k = 0; k < 60; k++) begin
      bus.cpu_pCounter = 13'h100 + 13'(k / 6);
      step();
      chk("nohalt", 32'(bus.halted), 32'd0);
    end
    chk("nohalt_runc", 32'(bus.run_cycles), 32'd60);
    chk("nohalt_cpu_rst", 32'(bus.cpu_rst), 32'd0);

    // abort during RUN
    bus.cpu_wrEn   = 1'b1;
    bus.cpu_addr   = 13'h20;
    bus.cpu_data   = 16'h5555;
    bus.load_start = 1'b1;
    bus.load_len   = 13'd2;
    #1;
    chk("ab_pass_addr", 32'(bus.ram_addr), 32'h20);
    step();
    bus.load_start = 1'b0;
    #1;
    chk("ab_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("ab_block", 32'(bus.ram_wrEn), 32'd0);
    chk("ab_addr", 32'(bus.ram_addr), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    #1;
    chk("ab_w0", 32'(bus.ram_data), 32'hBEEF);
    chk("ab_a0", 32'(bus.ram_addr), 32'd0);
    step();
    bus.in_data = 16'hCAFE;
    #1;
    chk("ab_a1", 32'(bus.ram_addr), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.cpu_wrEn = 1'b0;
    #1;
    chk("ab_rel", 32'(bus.busy), 32'd1);
    step();
    chk("ab_run", 32'(bus.cpu_rst), 32'd0);

    // reset mid-load; load_start in LOAD ignored
    bus.load_start = 1'b1;
    bus.load_len   = 13'd5;
    step();
    bus.load_len = 13'd1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0101;
    #1;
    chk("m_a0", 32'(bus.ram_addr), 32'd0);
    chk("m_wren", 32'(bus.ram_wrEn), 32'd1);
    step();
    bus.load_start = 1'b0;
    bus.in_data    = 16'h0202;
    #1;
    chk("m_ign_busy", 32'(bus.busy), 32'd1);
    chk("m_ign_ready", 32'(bus.in_ready), 32'd1);
    chk("m_a1", 32'(bus.ram_addr), 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("m_rst_wren", 32'(bus.ram_wrEn), 32'd0);
    chk("m_rst_ready", 32'(bus.in_ready), 32'd0);
    chk("m_rst_busy", 32'(bus.busy), 32'd0);
    w = wr_cnt;
    step();
    rst = 1'b0;
    #1;
    chk("m_idle_busy", 32'(bus.busy), 32'd0);
    chk("m_idle_ready", 32'(bus.in_ready), 32'd0);
    chk("m_idle_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("m_idle_runc", 32'(bus.run_cycles), 32'd0);
    step();
    step();
    chk("m_no_writes", 32'(wr_cnt - w), 32'd0);
    bus.in_valid = 1'b0;

    // zero-length load
    bus.load_start = 1'b1;
    bus.load_len   = 13'd0;
    w = wr_cnt;
    #1;
    chk("z_idle", 32'(bus.busy), 32'd0);
    step();
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b1;
    #1;
    chk("z_load_busy", 32'(bus.busy), 32'd1);
    chk("z_load_ready", 32'(bus.in_ready), 32'd1);
    chk("z_load_wren", 32'(bus.ram_wrEn), 32'd0);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("z_rel_busy", 32'(bus.busy), 32'd1);
    chk("z_rel_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    step();
    chk("z_run", 32'(bus.cpu_rst), 32'd0);
    chk("z_writes", 32'(wr_cnt - w), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
